// File: rtl/pcileech_ft601_responder_pkg.sv
// Shared FT601 bus types: word/byte-enable widths, bus FSM states and a saturating counter helper.
// Imported by the responder top and its FIFO.
package pcileech_ft601_responder_pkg;

    localparam int FT_DATA_W = 32;
    localparam int FT_BE_W   = 4;
    localparam int FT_TX_W   = FT_DATA_W + FT_BE_W;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RX_TURN  = 2'd1,
        ST_RX_READ  = 2'd2,
        ST_TX_WRITE = 2'd3
    } bus_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
        return (en && (v != 16'hFFFF)) ? (v + 16'd1) : v;
    endfunction

endpackage

// File: rtl/pcileech_ft601_responder_fifo.sv
// Generic first-word-fall-through FIFO with extended pointers, occupancy and next-cycle occupancy.
// Latency: head visible the cycle after push; push while full only succeeds with a concurrent pop.
module pcileech_ft601_responder_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  logic [WIDTH-1:0]      i_push_dat,
    input  logic                  i_pop,
    output logic [WIDTH-1:0]      o_head,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_count,
    output logic [DEPTH_LOG2:0]   o_count_nxt
);

    localparam int PW = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0] r_mem [2**DEPTH_LOG2];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Same low bits with differing MSB means the writer has lapped the reader.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                     (r_wr_ptr[PW-2:0] == r_rd_ptr[PW-2:0]);
    assign o_count = r_wr_ptr - r_rd_ptr;

    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    assign o_count_nxt = o_count + {{(PW-1){1'b0}}, w_do_push} - {{(PW-1){1'b0}}, w_do_pop};
    assign o_head      = r_mem[r_rd_ptr[PW-2:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[PW-2:0]] <= i_push_dat;
    end

endmodule

// File: rtl/pcileech_ft601_responder.sv
// FT601-style bus responder: host words buffered to the bus master (rx) and master writes buffered to d2h (tx).
// Latency: one-cycle RX turnaround before reads; backpressure via registered rxf_n/txe_n, h2d_ready and d2h_ready.
module pcileech_ft601_responder
    import pcileech_ft601_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int TXE_MARGIN = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FT_DATA_W-1:0]  ft601_data_in,
    input  logic [FT_BE_W-1:0]    ft601_be_in,
    output logic [FT_DATA_W-1:0]  ft601_data_out,
    output logic                  ft601_data_oe,
    output logic                  ft601_rxf_n,
    output logic                  ft601_txe_n,
    input  logic                  ft601_wr_n,
    input  logic                  ft601_rd_n,
    input  logic                  ft601_oe_n,
    input  logic                  ft601_siwu_n,
    input  logic [FT_DATA_W-1:0]  h2d_data,
    input  logic                  h2d_valid,
    output logic                  h2d_ready,
    output logic [FT_DATA_W-1:0]  d2h_data,
    output logic [FT_BE_W-1:0]    d2h_be,
    output logic                  d2h_valid,
    input  logic                  d2h_ready,
    output logic [15:0]           wr_overrun_cnt,
    output logic [15:0]           rd_underrun_cnt,
    output logic                  protocol_err
);

    localparam int PW = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0] DEPTH_W  = PW'(2**DEPTH_LOG2);
    localparam logic [PW-1:0] MARGIN_W = PW'(TXE_MARGIN);

    bus_state_t r_state;
    bus_state_t w_state_nxt;

    logic                 w_in_turn;
    logic                 w_in_read;
    logic                 w_in_write;
    logic                 w_data_oe;
    logic                 w_conflict;

    logic                 w_rx_push;
    logic                 w_rx_pop;
    logic [FT_DATA_W-1:0] w_rx_head;
    logic                 w_rx_full;
    logic                 w_rx_empty;
    logic [PW-1:0]        w_rx_count;
    logic [PW-1:0]        w_rx_count_nxt;

    logic                 w_tx_push;
    logic                 w_tx_pop;
    logic [FT_TX_W-1:0]   w_tx_head;
    logic                 w_tx_full;
    logic                 w_tx_empty;
    logic [PW-1:0]        w_tx_count;
    logic [PW-1:0]        w_tx_count_nxt;
    logic [PW-1:0]        w_tx_free_nxt;

    logic                 w_rd_strobe;
    logic                 w_wr_strobe;
    logic                 w_underrun;
    logic                 w_overrun;
    logic                 w_unused;

    logic                 r_rxf_n;
    logic                 r_txe_n;
    logic                 r_protocol_err;
    logic [15:0]          r_wr_overrun_cnt;
    logic [15:0]          r_rd_underrun_cnt;

    // Master driving oe_n and wr_n together is bus contention: abort whatever was in flight.
    assign w_conflict = ~ft601_oe_n & ~ft601_wr_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_conflict) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!ft601_oe_n && ft601_wr_n)      w_state_nxt = ST_RX_TURN;
                    else if (!ft601_wr_n && ft601_oe_n) w_state_nxt = ST_TX_WRITE;
                end
                ST_RX_TURN:  w_state_nxt = ft601_oe_n ? ST_IDLE : ST_RX_READ;
                ST_RX_READ:  if (ft601_oe_n) w_state_nxt = ST_IDLE;
                ST_TX_WRITE: if (ft601_wr_n) w_state_nxt = ST_IDLE;
                default:     w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_in_turn  = (r_state == ST_RX_TURN);
        w_in_read  = (r_state == ST_RX_READ);
        w_in_write = (r_state == ST_TX_WRITE);
        w_data_oe  = (w_in_turn | w_in_read) & ~ft601_oe_n;
    end

    assign w_rd_strobe = w_in_read & ~ft601_rd_n & ~ft601_oe_n & ~w_conflict;
    assign w_rx_pop    = w_rd_strobe & ~w_rx_empty;
    assign w_underrun  = w_rd_strobe & w_rx_empty;

    assign h2d_ready = rst_n & ~w_rx_full;
    assign w_rx_push = h2d_valid & h2d_ready;

    assign w_tx_pop    = ~w_tx_empty & d2h_ready;
    assign w_wr_strobe = w_in_write & ~ft601_wr_n & ~w_conflict;
    // A full tx FIFO still takes the word when d2h drains one in the same cycle.
    assign w_tx_push   = w_wr_strobe & (~w_tx_full | w_tx_pop);
    assign w_overrun   = w_wr_strobe & ~w_tx_push;

    pcileech_ft601_responder_fifo #(
        .WIDTH      (FT_DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_rx_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_rx_push),
        .i_push_dat  (h2d_data),
        .i_pop       (w_rx_pop),
        .o_head      (w_rx_head),
        .o_full      (w_rx_full),
        .o_empty     (w_rx_empty),
        .o_count     (w_rx_count),
        .o_count_nxt (w_rx_count_nxt)
    );

    pcileech_ft601_responder_fifo #(
        .WIDTH      (FT_TX_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_tx_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_tx_push),
        .i_push_dat  ({ft601_be_in, ft601_data_in}),
        .i_pop       (w_tx_pop),
        .o_head      (w_tx_head),
        .o_full      (w_tx_full),
        .o_empty     (w_tx_empty),
        .o_count     (w_tx_count),
        .o_count_nxt (w_tx_count_nxt)
    );

    assign w_tx_free_nxt = DEPTH_W - w_tx_count_nxt;

    // Flags look ahead to post-edge occupancy so the master sees them the cycle they become true.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rxf_n           <= 1'b1;
            r_txe_n           <= 1'b0;
            r_protocol_err    <= 1'b0;
            r_wr_overrun_cnt  <= '0;
            r_rd_underrun_cnt <= '0;
        end else begin
            r_rxf_n           <= (w_rx_count_nxt == '0);
            r_txe_n           <= (w_tx_free_nxt <= MARGIN_W);
            r_protocol_err    <= r_protocol_err | w_conflict;
            r_wr_overrun_cnt  <= sat_inc16(r_wr_overrun_cnt, w_overrun);
            r_rd_underrun_cnt <= sat_inc16(r_rd_underrun_cnt, w_underrun);
        end
    end

    assign ft601_data_oe   = w_data_oe;
    assign ft601_data_out  = (w_data_oe & ~w_rx_empty) ? w_rx_head : '0;
    assign ft601_rxf_n     = r_rxf_n;
    assign ft601_txe_n     = r_txe_n;
    assign d2h_valid       = ~w_tx_empty;
    assign d2h_data        = w_tx_head[FT_DATA_W-1:0];
    assign d2h_be          = w_tx_head[FT_TX_W-1:FT_DATA_W];
    assign wr_overrun_cnt  = r_wr_overrun_cnt;
    assign rd_underrun_cnt = r_rd_underrun_cnt;
    assign protocol_err    = r_protocol_err;

    assign w_unused = ^{ft601_siwu_n, w_rx_count, w_tx_count};

endmodule

// File: tb/tb_pcileech_ft601_responder.sv
// Bench for the FT601 responder: queue-based reference of both FIFOs and the bus handshake,
// directed scenarios followed by randomized bus/host traffic.
module tb_pcileech_ft601_responder;

    localparam int DEPTH  = 16;
    localparam int MARGIN = 2;
    localparam int M_IDLE = 0, M_TURN = 1, M_READ = 2, M_WRITE = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ft601_data_in;
    logic [3:0]  ft601_be_in;
    logic [31:0] ft601_data_out;
    logic        ft601_data_oe;
    logic        ft601_rxf_n;
    logic        ft601_txe_n;
    logic        ft601_wr_n;
    logic        ft601_rd_n;
    logic        ft601_oe_n;
    logic        ft601_siwu_n;
    logic [31:0] h2d_data;
    logic        h2d_valid;
    logic        h2d_ready;
    logic [31:0] d2h_data;
    logic [3:0]  d2h_be;
    logic        d2h_valid;
    logic        d2h_ready;
    logic [15:0] wr_overrun_cnt;
    logic [15:0] rd_underrun_cnt;
    logic        protocol_err;

    pcileech_ft601_responder #(.DEPTH_LOG2(4), .TXE_MARGIN(MARGIN)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ft601_data_in   (ft601_data_in),
        .ft601_be_in     (ft601_be_in),
        .ft601_data_out  (ft601_data_out),
        .ft601_data_oe   (ft601_data_oe),
        .ft601_rxf_n     (ft601_rxf_n),
        .ft601_txe_n     (ft601_txe_n),
        .ft601_wr_n      (ft601_wr_n),
        .ft601_rd_n      (ft601_rd_n),
        .ft601_oe_n      (ft601_oe_n),
        .ft601_siwu_n    (ft601_siwu_n),
        .h2d_data        (h2d_data),
        .h2d_valid       (h2d_valid),
        .h2d_ready       (h2d_ready),
        .d2h_data        (d2h_data),
        .d2h_be          (d2h_be),
        .d2h_valid       (d2h_valid),
        .d2h_ready       (d2h_ready),
        .wr_overrun_cnt  (wr_overrun_cnt),
        .rd_underrun_cnt (rd_underrun_cnt),
        .protocol_err    (protocol_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference: the two FIFOs as queues, bus phase, error tallies, and flag values expected now.
    logic [31:0] rxq[$];
    logic [35:0] txq[$];
    int          mode;
    int          ovr;
    int          und;
    bit          perr;
    bit          exp_rxf_n;
    bit          exp_txe_n;

    task automatic check_eq(input string tag, input logic [35:0] got, input logic [35:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        rxq.delete();
        txq.delete();
        mode      = M_IDLE;
        ovr       = 0;
        und       = 0;
        perr      = 1'b0;
        exp_rxf_n = 1'b1;
        exp_txe_n = 1'b0;
    endtask

    task automatic bus_idle();
        ft601_oe_n = 1'b1;
        ft601_wr_n = 1'b1;
        ft601_rd_n = 1'b1;
    endtask

    // Inputs are already set (1 time unit after an edge); check, step one edge, advance the model.
    task automatic tick();
        bit drv, conflict, tx_pop, rx_pop, und_inc, wr, tx_push, ovr_inc, rx_push;
        logic [31:0] exp_dout;
        logic [35:0] wr_word;
        int nm;
        #2;
        drv      = (mode == M_TURN || mode == M_READ) && !ft601_oe_n;
        exp_dout = (drv && rxq.size() > 0) ? rxq[0] : 32'h0;
        check_eq("data_oe", 36'(ft601_data_oe), 36'(drv));
        check_eq("data_out", 36'(ft601_data_out), 36'(exp_dout));
        check_eq("h2d_ready", 36'(h2d_ready), 36'(rxq.size() < DEPTH));
        check_eq("d2h_valid", 36'(d2h_valid), 36'(txq.size() > 0));
        if (txq.size() > 0) check_eq("d2h_word", {d2h_be, d2h_data}, txq[0]);
        check_eq("rxf_n", 36'(ft601_rxf_n), 36'(exp_rxf_n));
        check_eq("txe_n", 36'(ft601_txe_n), 36'(exp_txe_n));
        check_eq("overrun", 36'(wr_overrun_cnt), 36'(ovr));
        check_eq("underrun", 36'(rd_underrun_cnt), 36'(und));
        check_eq("protocol_err", 36'(protocol_err), 36'(perr));

        conflict = !ft601_oe_n && !ft601_wr_n;
        tx_pop   = d2h_ready && txq.size() > 0;
        rx_pop   = !conflict && mode == M_READ && !ft601_rd_n && !ft601_oe_n && rxq.size() > 0;
        und_inc  = !conflict && mode == M_READ && !ft601_rd_n && !ft601_oe_n && rxq.size() == 0;
        wr       = !conflict && mode == M_WRITE && !ft601_wr_n;
        tx_push  = wr && (txq.size() < DEPTH || tx_pop);
        ovr_inc  = wr && !tx_push;
        rx_push  = h2d_valid && rxq.size() < DEPTH;
        wr_word  = {ft601_be_in, ft601_data_in};

        nm = mode;
        if (conflict) nm = M_IDLE;
        else if (mode == M_IDLE) begin
            if (!ft601_oe_n && ft601_wr_n) nm = M_TURN;
            else if (!ft601_wr_n && ft601_oe_n) nm = M_WRITE;
        end
        else if (mode == M_TURN)  nm = ft601_oe_n ? M_IDLE : M_READ;
        else if (mode == M_READ)  nm = ft601_oe_n ? M_IDLE : M_READ;
        else if (mode == M_WRITE) nm = ft601_wr_n ? M_IDLE : M_WRITE;

        if (rx_push) rxq.push_back(h2d_data);
        @(posedge clk);
        if (rx_pop)  void'(rxq.pop_front());
        if (tx_pop)  void'(txq.pop_front());
        if (tx_push) txq.push_back(wr_word);
        if (ovr_inc) ovr++;
        if (und_inc) und++;
        perr      = perr | conflict;
        mode      = nm;
        exp_rxf_n = (rxq.size() == 0);
        exp_txe_n = ((DEPTH - txq.size()) <= MARGIN);
        #1;
    endtask

    task automatic push_h2d(input logic [31:0] w);
        h2d_valid = 1'b1;
        h2d_data  = w;
        tick();
        h2d_valid = 1'b0;
    endtask

    // One entry cycle into TX_WRITE followed by n stored-or-dropped words.
    task automatic master_write(input int n);
        ft601_oe_n    = 1'b1;
        ft601_wr_n    = 1'b0;
        ft601_data_in = $urandom;
        ft601_be_in   = 4'($urandom_range(0, 15));
        tick();
        for (int i = 0; i < n; i++) begin
            ft601_data_in = $urandom;
            ft601_be_in   = 4'($urandom_range(0, 15));
            tick();
        end
        bus_idle();
        tick();
    endtask

    // Turnaround then n read strobes, then release oe_n.
    task automatic master_read(input int n);
        ft601_wr_n = 1'b1;
        ft601_oe_n = 1'b0;
        ft601_rd_n = 1'b1;
        tick();
        tick();
        ft601_rd_n = 1'b0;
        for (int i = 0; i < n; i++) tick();
        bus_idle();
        tick();
    endtask

    initial begin
        rst_n         = 1'b0;
        ft601_data_in = '0;
        ft601_be_in   = '0;
        ft601_siwu_n  = 1'b1;
        h2d_data      = '0;
        h2d_valid     = 1'b0;
        d2h_ready     = 1'b0;
        bus_idle();
        model_reset();

        #12;
        check_eq("rst_rxf_n", 36'(ft601_rxf_n), 36'(1));
        check_eq("rst_txe_n", 36'(ft601_txe_n), 36'(0));
        check_eq("rst_data_oe", 36'(ft601_data_oe), 36'(0));
        check_eq("rst_data_out", 36'(ft601_data_out), 36'(0));
        check_eq("rst_h2d_ready", 36'(h2d_ready), 36'(0));
        check_eq("rst_d2h_valid", 36'(d2h_valid), 36'(0));
        check_eq("rst_counters", 36'({wr_overrun_cnt, rd_underrun_cnt}), 36'(0));
        check_eq("rst_perr", 36'(protocol_err), 36'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Four host words read back by the master in order.
        push_h2d(32'h11111111);
        push_h2d(32'h22222222);
        push_h2d(32'h33333333);
        push_h2d(32'h44444444);
        master_read(4);

        // Reads against an empty rx FIFO.
        master_read(3);
        check_eq("underrun_3", 36'(rd_underrun_cnt), 36'(3));

        // Overfill tx with no d2h drain, then drain.
        master_write(20);
        check_eq("overrun_4", 36'(wr_overrun_cnt), 36'(4));
        d2h_ready = 1'b1;
        for (int i = 0; i < 18; i++) tick();
        d2h_ready = 1'b0;

        // Contention with data buffered on both sides.
        push_h2d($urandom);
        push_h2d($urandom);
        master_write(2);
        ft601_oe_n = 1'b0;
        ft601_wr_n = 1'b0;
        tick();
        bus_idle();
        tick();
        check_eq("perr_sticky", 36'(protocol_err), 36'(1));
        master_read(2);
        d2h_ready = 1'b1;
        tick();
        tick();
        d2h_ready = 1'b0;

        // Full tx with concurrent drain: every write lands across pointer wrap.
        master_write(16);
        ft601_wr_n    = 1'b0;
        ft601_data_in = $urandom;
        tick();
        d2h_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            ft601_data_in = $urandom;
            ft601_be_in   = 4'($urandom_range(0, 15));
            tick();
        end
        bus_idle();
        for (int i = 0; i < 18; i++) tick();
        d2h_ready = 1'b0;

        // Randomized bus segments with random host traffic.
        for (int seg = 0; seg < 80; seg++) begin
            int kind, len;
            kind = $urandom_range(0, 9);
            len  = (kind == 9) ? 1 : $urandom_range(1, 8);
            for (int c = 0; c < len; c++) begin
                bus_idle();
                if (kind >= 1 && kind <= 4) begin
                    ft601_oe_n = 1'b0;
                    ft601_rd_n = 1'($urandom_range(0, 1));
                end else if (kind >= 5 && kind <= 8) begin
                    ft601_wr_n    = 1'b0;
                    ft601_data_in = $urandom;
                    ft601_be_in   = 4'($urandom_range(0, 15));
                end else if (kind == 9) begin
                    ft601_oe_n = 1'b0;
                    ft601_wr_n = 1'b0;
                end
                h2d_valid = 1'($urandom_range(0, 1));
                h2d_data  = $urandom;
                d2h_ready = 1'($urandom_range(0, 1));
                tick();
            end
        end
        bus_idle();
        h2d_valid = 1'b0;
        d2h_ready = 1'b0;
        tick();

        // Reset in the middle of a read burst with five words pending.
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_rxf_n", 36'(ft601_rxf_n), 36'(1));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 5; i++) push_h2d($urandom);
        ft601_oe_n = 1'b0;
        tick();
        tick();
        check_eq("pre_rst_oe", 36'(ft601_data_oe), 36'(1));
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_rxf_n2", 36'(ft601_rxf_n), 36'(1));
        check_eq("mid_rst_data_oe", 36'(ft601_data_oe), 36'(0));
        check_eq("mid_rst_h2d_ready", 36'(h2d_ready), 36'(0));
        bus_idle();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        push_h2d(32'hA5A5_0001);
        push_h2d($urandom);
        master_read(2);
        master_write(3);
        d2h_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
